// File: rtl/mesh_sequencer.sv
// Job-level controller for the NxN systolic mesh: clear, feed K beats, wait for done, drain.
// Optional build macro MESH_SEQ_TIMEOUT_EN adds a WAIT_DONE watchdog that raises error_o.
module mesh_sequencer #(
  parameter int unsigned N              = 2,
  parameter int unsigned K_WIDTH        = 16,
  parameter int unsigned DRAIN_CYCLES   = 2*N-1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               start_i,
  input  logic [K_WIDTH-1:0] k_len_i,
  output logic               busy_o,
  output logic               job_done_o,
  output logic               error_o,
  input  logic               feed_ready_i,
  output logic               feed_pop_o,
  output logic               mesh_clear_n_o,
  output logic               mesh_valid_o,
  output logic               mesh_last_o,
  input  logic               mesh_done_i,
  output logic [N*N-1:0]     select_acc_o,
  output logic               drain_valid_o
);

  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_WAIT_DONE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [K_WIDTH-1:0]   k_len_q;
  logic [K_WIDTH-1:0]   beat_cnt_q;
  logic [DRAIN_W-1:0]   drain_cnt_q;
  logic                 accept;
  logic                 beat_last;
  logic                 drain_last;
  logic                 timeout_hit;

  logic                 busy_d;
  logic                 job_done_d;
  logic                 clear_n_d;
  logic                 drain_d;

  assign accept     = (state_q == S_IDLE) && start_i;
  assign beat_last  = (beat_cnt_q == k_len_q - K_WIDTH'(1));
  assign drain_last = (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1));

`ifdef MESH_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] wait_cnt_q;

  assign timeout_hit = (state_q == S_WAIT_DONE) && !mesh_done_i &&
                       (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Restarts from zero on every WAIT_DONE entry since it is held clear elsewhere.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wait_cnt_q <= '0;
      error_o    <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == S_WAIT_DONE) ? wait_cnt_q + TO_W'(1) : '0;
      if (accept) begin
        error_o <= 1'b0;
      end else if (timeout_hit) begin
        error_o <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign error_o     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (start_i) state_d = S_CLEAR;
      S_CLEAR:     state_d = S_FEED;
      S_FEED:      if (feed_ready_i && beat_last) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (mesh_done_i) begin
          state_d = S_DRAIN;
        end else if (timeout_hit) begin
          state_d = S_DONE;
        end
      end
      S_DRAIN:     if (drain_last) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output logic: feed-side strobes are combinational, the rest are staged from state_d
  always_comb begin
    feed_pop_o   = (state_q == S_FEED) && feed_ready_i;
    mesh_valid_o = feed_pop_o;
    mesh_last_o  = feed_pop_o && beat_last;
    busy_d       = (state_d != S_IDLE);
    job_done_d   = (state_d == S_DONE);
    clear_n_d    = (state_d != S_CLEAR);
    drain_d      = (state_d == S_DRAIN);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      busy_o         <= 1'b0;
      job_done_o     <= 1'b0;
      mesh_clear_n_o <= 1'b1;
      select_acc_o   <= '0;
      drain_valid_o  <= 1'b0;
    end else begin
      busy_o         <= busy_d;
      job_done_o     <= job_done_d;
      mesh_clear_n_o <= clear_n_d;
      select_acc_o   <= drain_d ? '1 : '0;
      drain_valid_o  <= drain_d;
    end
  end

  // Job counters
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      if (accept) begin
        k_len_q    <= (k_len_i == '0) ? K_WIDTH'(1) : k_len_i;
        beat_cnt_q <= '0;
      end else if (feed_pop_o) begin
        beat_cnt_q <= beat_cnt_q + K_WIDTH'(1);
      end
      drain_cnt_q <= (state_q == S_DRAIN) ? drain_cnt_q + DRAIN_W'(1) : '0;
    end
  end

endmodule

// File: tb/tb_mesh_sequencer.sv
// Randomized bench for mesh_sequencer against a cycle-timeline reference model.
// Define MESH_SEQ_TIMEOUT_EN for both files to also exercise the watchdog path.
module tb_mesh_sequencer;

  localparam int N     = 2;
  localparam int KW    = 16;
  localparam int DRAIN = 2*N-1;
  localparam int TO    = 16;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          start_i;
  logic [KW-1:0] k_len_i;
  logic          busy_o;
  logic          job_done_o;
  logic          error_o;
  logic          feed_ready_i;
  logic          feed_pop_o;
  logic          mesh_clear_n_o;
  logic          mesh_valid_o;
  logic          mesh_last_o;
  logic          mesh_done_i;
  logic [N*N-1:0] select_acc_o;
  logic          drain_valid_o;

  int total = 0;
  int bad   = 0;
  int job_id = 0;
  bit exp_err = 1'b0;

  mesh_sequencer #(
    .N(N),
    .K_WIDTH(KW),
    .DRAIN_CYCLES(DRAIN),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .start_i(start_i),
    .k_len_i(k_len_i),
    .busy_o(busy_o),
    .job_done_o(job_done_o),
    .error_o(error_o),
    .feed_ready_i(feed_ready_i),
    .feed_pop_o(feed_pop_o),
    .mesh_clear_n_o(mesh_clear_n_o),
    .mesh_valid_o(mesh_valid_o),
    .mesh_last_o(mesh_last_o),
    .mesh_done_i(mesh_done_i),
    .select_acc_o(select_acc_o),
    .drain_valid_o(drain_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string ph, input bit busy, input bit done, input bit err,
                            input bit pop, input bit clr_n, input bit last, input bit drain);
    logic [31:0] sel_exp;
    sel_exp = drain ? 32'((1 << (N*N)) - 1) : 32'd0;
    check_eq({ph, ".busy"},    32'(busy_o),         32'(busy));
    check_eq({ph, ".done"},    32'(job_done_o),     32'(done));
    check_eq({ph, ".err"},     32'(error_o),        32'(err));
    check_eq({ph, ".pop"},     32'(feed_pop_o),     32'(pop));
    check_eq({ph, ".valid"},   32'(mesh_valid_o),   32'(pop));
    check_eq({ph, ".clr_n"},   32'(mesh_clear_n_o), 32'(clr_n));
    check_eq({ph, ".last"},    32'(mesh_last_o),    32'(last));
    check_eq({ph, ".sel"},     32'(select_acc_o),   sel_exp);
    check_eq({ph, ".drain_v"}, 32'(drain_valid_o),  32'(drain));
  endtask

  // mode: 0 ready always, 1 ready on even cycles, 2 random ready.
  // dly: cycles from last beat to mesh done (0 = already high at WAIT_DONE entry, <0 = never).
  // noise: 0 no extra start, 1 start held through the job, 2 random start pulses.
  task automatic run_job(input int k_in, input int mode, input int dly, input int noise);
    int  k_eff;
    int  pops;
    int  last_c;
    int  done_c;
    int  dstart;
    int  endc;
    bit  r;
    bit  exp_pop;
    bit  exp_last;
    bit  exp_drain;
    bit  finished;
    bit  to_job;
    k_eff    = (k_in == 0) ? 1 : k_in;
    pops     = 0;
    last_c   = -1;
    done_c   = 0;
    dstart   = 0;
    endc     = -1;
    finished = 1'b0;
    to_job   = (dly < 0);
    job_id++;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_i);
      #1;
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
      feed_ready_i = r;
      start_i = (c == 0) || (c >= 1 && ((noise == 1) || (noise == 2 && $urandom_range(0, 1) == 1)));
      k_len_i = (c == 0) ? KW'(k_in) : KW'($urandom);
      exp_pop  = (c >= 2) && (pops < k_eff) && r;
      exp_last = exp_pop && (pops == k_eff - 1);
      if (exp_pop) pops++;
      if (exp_last) begin
        last_c = c;
        if (to_job) begin
          endc = last_c + 1 + TO;
        end else begin
          done_c = last_c + dly;
          dstart = ((done_c > last_c + 1) ? done_c : last_c + 1) + 1;
          endc   = dstart + DRAIN;
        end
      end
      mesh_done_i = (last_c >= 0) && !to_job && (c >= done_c);
      if (c == 1) exp_err = 1'b0;
      if (to_job && c == endc) exp_err = 1'b1;
      exp_drain = (last_c >= 0) && !to_job && (c >= dstart) && (c < dstart + DRAIN);
      @(negedge clk_i);
      check_outs($sformatf("j%0d.c%0d", job_id, c), (c >= 1), (c == endc), exp_err,
                 exp_pop, (c != 1), exp_last, exp_drain);
      if (c == endc) begin
        finished = 1'b1;
        break;
      end
    end
    check_eq($sformatf("j%0d.finished", job_id), 32'(finished), 32'd1);
    start_i = 1'b0;
  endtask

  task automatic reset_mid_feed();
    job_id++;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i);
      #1;
      start_i      = (c == 0);
      k_len_i      = KW'(8);
      feed_ready_i = 1'b1;
      mesh_done_i  = 1'b0;
      @(negedge clk_i);
      check_eq($sformatf("j%0d.c%0d.pop", job_id, c), 32'(feed_pop_o), 32'(c >= 2));
    end
    @(posedge clk_i);
    #1;
    rstn_i = 1'b0;
    exp_err = 1'b0;
    #1;
    check_outs("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_eq("rst_hold.done", 32'(job_done_o), 32'd0);
      check_eq("rst_hold.busy", 32'(busy_o), 32'd0);
    end
    rstn_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      check_outs("post_rst", 1'b0, 1'b0, 1'b0, 1'b1 & 1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rstn_i       = 1'b0;
    start_i      = 1'b0;
    k_len_i      = '0;
    feed_ready_i = 1'b1;
    mesh_done_i  = 1'b0;
    repeat (2) @(negedge clk_i);
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    rstn_i = 1'b1;

    run_job(4, 0, 5, 0);
    run_job(6, 1, 2, 0);
    run_job(0, 2, 3, 0);
    run_job(5, 2, 0, 1);
    run_job(3, 0, 1, 2);
    reset_mid_feed();
    for (int j = 0; j < 20; j++) begin
      run_job(int'($urandom_range(0, 12)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 8)), int'($urandom_range(0, 2)));
    end
`ifdef MESH_SEQ_TIMEOUT_EN
    run_job(3, 0, -1, 0);
    run_job(2, 0, 2, 0);
    run_job(4, 2, -1, 2);
    run_job(1, 0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
